// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
// Contents: FSM state encoding, opcode field bounds, default reset PC, PC alignment helper.
package instruction_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_FLUSH = 3'd3,
    S_HOLD  = 3'd4
  } if_state_e;

  localparam int          OPC_MSB          = 31;
  localparam int          OPC_LSB          = 26;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  // Instruction addresses are word aligned; low two bits of any target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues one outstanding imem read, holds the word for decode.
// Latency: imem_req 1 cycle after reset release; if_valid 1 cycle after imem_rvalid.
// Backpressure: if_ready low holds if_valid/if_instr/if_pc stable and no new request issues.
// Ports: clk/reset_n; imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata (memory side);
//        if_valid/if_ready/if_instr/if_opcode/if_pc/if_pc_plus4 (decode side);
//        redirect/redirect_pc (branch/jump target from downstream).
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [5:0]  if_opcode,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  if_state_e   state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] if_pc_q;
  logic        req_q;
  logic        valid_q;

  logic [31:0] redir_pc_d;
  logic [31:0] pc_inc_d;

  assign redir_pc_d = align_pc(redirect_pc);
  assign pc_inc_d   = pc_q + 32'd4;

  // req_q/valid_q are set alongside the state they belong to, so both outputs
  // come straight from flops and if_ready never reaches if_valid combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      if_pc_q <= RESET_PC;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_q <= S_REQ;
          req_q   <= 1'b1;
        end
        S_REQ: begin
          if (redirect) begin
            pc_q <= redir_pc_d;
            // A request granted in the same cycle is already in flight and
            // must be drained without being used.
            if (imem_gnt) begin
              state_q <= S_FLUSH;
              req_q   <= 1'b0;
            end
          end else if (imem_gnt) begin
            state_q <= S_WAIT;
            req_q   <= 1'b0;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc_q <= redir_pc_d;
            if (imem_rvalid) begin
              state_q <= S_REQ;
              req_q   <= 1'b1;
            end else begin
              state_q <= S_FLUSH;
            end
          end else if (imem_rvalid) begin
            instr_q <= imem_rdata;
            if_pc_q <= pc_q;
            state_q <= S_HOLD;
            valid_q <= 1'b1;
          end
        end
        S_FLUSH: begin
          if (redirect) pc_q <= redir_pc_d;
          if (imem_rvalid) begin
            state_q <= S_REQ;
            req_q   <= 1'b1;
          end
        end
        S_HOLD: begin
          // Redirect wins over the handshake: the held word is on the wrong path.
          if (redirect) begin
            pc_q    <= redir_pc_d;
            state_q <= S_REQ;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
          end else if (if_ready) begin
            pc_q    <= pc_inc_d;
            state_q <= S_REQ;
            valid_q <= 1'b0;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_opcode   = instr_q[OPC_MSB:OPC_LSB];
  assign if_pc       = if_pc_q;
  assign if_pc_plus4 = if_pc_q + 32'd4;

endmodule
